// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared binary32 format constants and the divider FSM state
//                type for the floating-point divider.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int FP_BIAS  = 127;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    // Exponent field patterns for signed infinity and signed zero
    localparam logic [FP_EXP_W-1:0] FP_EXP_INF  = 8'hFF;
    localparam logic [FP_EXP_W-1:0] FP_EXP_ZERO = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2
    } fp_div_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_mant_divider.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mant_divider
//  Description : Restoring radix-2 mantissa divider. 26 iterations produce a
//                26-bit quotient with q[25] as the integer bit. fin is high
//                during the cycle in which the final iteration is performed,
//                so q/rem_nz are final in the cycle after fin.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_mant_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] mant_a,
    input  logic [23:0] mant_b,
    output logic [25:0] q,
    output logic        rem_nz,
    output logic        fin
);

    // Counter value that marks "all iterations done / idle"
    localparam logic [4:0] c_STEPS = 5'd26;

    logic [24:0] r_rem;
    logic [23:0] r_mant_b;
    logic [25:0] r_q;
    logic [4:0]  r_cnt;

    logic        w_active;
    logic        w_ge;
    logic [24:0] w_sub;
    logic [24:0] w_rem_next;

    assign w_active   = (r_cnt != c_STEPS);
    assign w_ge       = (r_rem >= {1'b0, r_mant_b});
    assign w_sub      = r_rem - {1'b0, r_mant_b};
    assign w_rem_next = w_ge ? w_sub : r_rem;

    assign q      = r_q;
    assign rem_nz = (r_rem != 25'd0);
    assign fin    = w_active && (r_cnt == c_STEPS - 5'd1);

    // One compare/subtract/shift iteration per cycle until the counter expires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem    <= 25'd0;
            r_mant_b <= 24'd0;
            r_q      <= 26'd0;
            r_cnt    <= c_STEPS;
        end else if (load) begin
            r_rem    <= {1'b0, mant_a};
            r_mant_b <= mant_b;
            r_q      <= 26'd0;
            r_cnt    <= 5'd0;
        end else if (w_active) begin
            // After a subtract the remainder is below mant_b, so the shift
            // never loses a set bit
            r_rem <= w_rem_next << 1;
            r_q   <= {r_q[24:0], w_ge};
            r_cnt <= r_cnt + 5'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/floating_point_divider.sv
`default_nettype none
// ============================================================================
//  Module      : floating_point_divider
//  Description : Sequential binary32 divider (a / b) with start/done
//                handshake. Denormals flush to zero. Build macro
//                FP_DIV_RND_EN selects round-to-nearest-even; without it the
//                quotient is truncated.
//  Revision    : 1.0  initial release
// ============================================================================
module floating_point_divider
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);

    fp_div_state_t      r_state;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic               r_spec_dbz;
    logic               r_spec_zero;

    logic               w_accept;
    logic               w_a_zero;
    logic               w_b_zero;
    logic [9:0]         w_exp_in;
    logic [25:0]        w_q;
    logic               w_rem_nz;
    logic               w_fin;

    logic [22:0]        w_frac;
    logic signed [9:0]  w_e;
    logic [22:0]        w_frac_fin;
    logic signed [9:0]  w_e_fin;
    logic [31:0]        w_result;
    logic               w_ov;
    logic               w_uf;

    assign w_accept = (r_state == IDLE) && start;
    assign w_a_zero = (a[30:23] == FP_EXP_ZERO);
    assign w_b_zero = (b[30:23] == FP_EXP_ZERO);
    assign w_exp_in = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'(FP_BIAS);

    fp_mant_divider u_mant_div (
        .clk    (clk),
        .rst    (rst),
        .load   (w_accept && !w_a_zero && !w_b_zero),
        .mant_a ({1'b1, a[FP_MAN_W-1:0]}),
        .mant_b ({1'b1, b[FP_MAN_W-1:0]}),
        .q      (w_q),
        .rem_nz (w_rem_nz),
        .fin    (w_fin)
    );

    // Normalise the quotient to 1.f form and take the exponent back by one
    // when the integer bit is clear
    always_comb begin
        w_frac = w_q[25] ? w_q[24:2] : w_q[23:1];
        w_e    = w_q[25] ? r_exp : (r_exp - 10'sd1);
    end

`ifdef FP_DIV_RND_EN
    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;
    logic [23:0] w_frac_inc;

    // Round to nearest even; a carry out of the fraction renormalises to 1.0
    always_comb begin
        w_guard    = w_q[25] ? w_q[1] : w_q[0];
        w_sticky   = w_q[25] ? (w_q[0] | w_rem_nz) : w_rem_nz;
        w_inc      = w_guard & (w_sticky | w_frac[0]);
        w_frac_inc = {1'b0, w_frac} + {23'd0, w_inc};
        w_frac_fin = w_frac_inc[22:0];
        w_e_fin    = w_frac_inc[23] ? (w_e + 10'sd1) : w_e;
    end
`else
    logic w_unused_rem_nz;
    assign w_unused_rem_nz = w_rem_nz | w_q[0];

    // Truncation: guard and sticky bits are simply dropped
    always_comb begin
        w_frac_fin = w_frac;
        w_e_fin    = w_e;
    end
`endif

    // Pack the final quotient, applying special cases and range saturation
    always_comb begin
        w_result = {r_sign, w_e_fin[7:0], w_frac_fin};
        w_ov     = 1'b0;
        w_uf     = 1'b0;
        if (r_spec_dbz) begin
            w_result = {r_sign, FP_EXP_INF, 23'd0};
        end else if (r_spec_zero) begin
            w_result = {r_sign, FP_EXP_ZERO, 23'd0};
        end else if (w_e_fin >= 10'sd255) begin
            w_result = {r_sign, FP_EXP_INF, 23'd0};
            w_ov     = 1'b1;
        end else if (w_e_fin <= 10'sd0) begin
            w_result = {r_sign, FP_EXP_ZERO, 23'd0};
            w_uf     = 1'b1;
        end
    end

    // Control FSM with registered handshake, result and flag outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_exp       <= 10'sd0;
            r_spec_dbz  <= 1'b0;
            r_spec_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= 32'd0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        div_by_zero <= 1'b0;
                        r_sign      <= a[31] ^ b[31];
                        r_exp       <= w_exp_in;
                        r_spec_dbz  <= w_b_zero;
                        r_spec_zero <= w_a_zero;
                        r_state     <= (w_a_zero || w_b_zero) ? NORM : DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (w_fin) begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    result      <= w_result;
                    overflow    <= w_ov;
                    underflow   <= w_uf;
                    div_by_zero <= r_spec_dbz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_floating_point_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_floating_point_divider
//  Description : Directed self-checking bench for floating_point_divider.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_floating_point_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    floating_point_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Issue one operation and check latency, result, flags and the done pulse
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] exp_res, input logic [2:0] exp_flags,
                          input int exp_lat);
        int cyc;
        bit seen;
        @(negedge clk);
        a = op_a;
        b = op_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen = 1;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, result, exp_res);
        check({tag, " flags_ov_uf_dbz"}, 32'({overflow, underflow, div_by_zero}), 32'(exp_flags));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        int n_done;
        logic [31:0] first_res;
        logic [31:0] third_exp;

        rst   = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {busy, done, overflow, underflow, div_by_zero, 27'd0}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("6/2",      32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 27);
        run_op("-7.5/2.5", 32'hC0F00000, 32'h40200000, 32'hC0400000, 3'b000, 27);
`ifdef FP_DIV_RND_EN
        third_exp = 32'h3EAAAAAB;
`else
        third_exp = 32'h3EAAAAAA;
`endif
        run_op("1/3",      32'h3F800000, 32'h40400000, third_exp,    3'b000, 27);
        run_op("div0",     32'hBF800000, 32'h00000000, 32'hFF800000, 3'b001, 1);
        run_op("zero_a",   32'h00000000, 32'h40000000, 32'h00000000, 3'b000, 1);
        run_op("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, 27);
        run_op("underflow",32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 27);

        // A start pulsed while busy must be ignored
        @(negedge clk);
        a = 32'h40C00000;
        b = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_done    = 0;
        first_res = 32'd0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 5) begin
                a = 32'h3F800000;
                b = 32'h40400000;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                n_done++;
                first_res = result;
            end
        end
        check("busy_start done_count", 32'(n_done), 32'd1);
        check("busy_start result", first_res, 32'h40400000);

        // Reset mid-operation aborts without a done
        @(negedge clk);
        a = 32'hC0F00000;
        b = 32'h40200000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst outputs", {busy, done, overflow, underflow, div_by_zero, 27'd0}, 32'd0);
        check("midrst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (cyc = 0; cyc < 35; cyc++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("midrst no_done", 32'(n_done), 32'd0);
        check("midrst idle_busy", 32'(busy), 32'd0);

        run_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 27);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
